// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter and its sibling rx/detector benches.
//   tx_state_e : FSM state encodings
//   LEN_W/DIV_W: counter widths for the default WIDTH=8, DIV=4 build
//   len_w_f/div_w_f: the same width rules for other parameterisations
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV   = 4;
    localparam int unsigned LEN_W     = $clog2(DEF_WIDTH + 1);
    localparam int unsigned DIV_W     = $clog2(DEF_DIV) | 1;

    // Width able to hold 0..width (bit count field).
    function automatic int unsigned len_w_f(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Width of the clock divider counter; never zero, even for div == 1.
    function automatic int unsigned div_w_f(input int unsigned div);
        return $clog2(div) | 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-time divider: counts 0..DIV-1 and wraps while running.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : hold counter at 0 (block idle / word start)
//   tick_c     : combinational, high in the last clock of each bit time
module serial_bit_timer
    import serial_tx_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic tick_c
);

    localparam int unsigned CNT_W = div_w_f(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_c = !clear_i && (cnt_q == CNT_W'(DIV - 1));

    // Next count: park at zero when cleared, wrap on terminal count.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: takes a 1..WIDTH bit word over valid/ready and
// sends it MSB-first on x_out, DIV clocks per bit, followed by GAP idle bit-times.
//   clk, reset : clock, synchronous active-high reset
//   in_data    : word; in_data[len-1:0] is sent, msb of that field first
//   in_len     : bit count; 0 or >WIDTH means WIDTH
//   in_valid   : word offered; in_ready: accepting (idle only)
//   x_out      : serial line, IDLE_LEVEL when not sending
//   bit_strb   : pulse in the first clock of every data bit
//   busy       : high while sending or in the gap
//   done       : pulse when the last data bit's hold ends
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIV        = 4,
    parameter int unsigned GAP        = 1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH+1)-1:0] in_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       x_out,
    output logic                       bit_strb,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned LEN_WL   = len_w_f(WIDTH);
    localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned CNT_W    = (LEN_WL > GAP_W) ? LEN_WL : GAP_W;
    localparam int unsigned GAP_LOAD = (GAP > 0) ? GAP - 1 : 0;

    tx_state_e         state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              x_q,     x_d;
    logic              strb_q,  strb_d;
    logic              busy_q,  busy_d;
    logic              ready_q, ready_d;
    logic              done_q,  done_d;

    logic              timer_clear_c;
    logic              tick_c;
    logic [LEN_WL-1:0] len_eff_c;
    logic [WIDTH-1:0]  aligned_c;

    // Timer only runs while a word or its gap is on the line.
    assign timer_clear_c = !((state_q == ST_SHIFT) || (state_q == ST_GAP));

    serial_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (timer_clear_c),
        .tick_c  (tick_c)
    );

    // Clamp length, then left-justify the field so the word's msb sits at shift[WIDTH-1].
    always_comb begin
        len_eff_c = in_len;
        if ((in_len == '0) || (in_len > LEN_WL'(WIDTH))) begin
            len_eff_c = LEN_WL'(WIDTH);
        end
        aligned_c = in_data << (LEN_WL'(WIDTH) - len_eff_c);
    end

    // Next-state and output logic. cnt_q counts remaining bits in SHIFT, remaining bit-times in GAP.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        strb_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_d     = IDLE_LEVEL;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (in_valid && ready_q) begin
                    state_d = ST_SHIFT;
                    shift_d = aligned_c;
                    cnt_d   = CNT_W'(len_eff_c - LEN_WL'(1));
                    x_d     = aligned_c[WIDTH-1];
                    strb_d  = 1'b1;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (tick_c) begin
                    if (cnt_q == '0) begin
                        x_d    = IDLE_LEVEL;
                        done_d = 1'b1;
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            cnt_d   = CNT_W'(GAP_LOAD);
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q << 1;
                        x_d     = shift_q[WIDTH-2];
                        strb_d  = 1'b1;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                x_d = IDLE_LEVEL;
                if (tick_c) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                // Unused encoding: recover to the post-reset condition.
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
                x_d     = IDLE_LEVEL;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            x_q     <= IDLE_LEVEL;
            strb_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = ready_q;
    assign x_out    = x_q;
    assign bit_strb = strb_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
